// File: rtl/fifo_sync.sv
// fifo_sync: parametrised synchronous FIFO with occupancy count, threshold flags
// and sticky overflow/underflow; read data is registered (one-cycle latency).
module fifo_sync #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_acc, rd_acc;

    assign full         = count == CW'(DEPTH);
    assign empty        = count == '0;
    assign almost_full  = int'(count) >= AF_LEVEL;
    assign almost_empty = int'(count) <= AE_LEVEL;
    // A read frees a slot in the same edge, so a full FIFO still takes a write.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk)
        if (reset && !clear && wr_acc) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            dout      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
            count <= count + CW'(wr_acc) - CW'(rd_acc);
            if (wr_en && !wr_acc) overflow <= 1'b1;
            if (rd_en && !rd_acc) underflow <= 1'b1;
        end
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed vector table, async-reset check and randomized run
// against a queue-based reference model of fifo_sync.
module tb_fifo_sync;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AFL   = DEPTH - 1;
    localparam int AEL   = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(dout), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr, wr, rd;
        logic [7:0] d;
        int         ecount;
        logic [7:0] edout;
        logic       eov, eud;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags are derived from the expected occupancy using the threshold rules.
    task automatic chk_state(input string tag, input int ec, input int ed, input bit eov, input bit eud);
        chk({tag, " count"}, int'(count), ec);
        chk({tag, " dout"}, int'(dout), ed);
        chk({tag, " full"}, int'(full), int'(ec == DEPTH));
        chk({tag, " empty"}, int'(empty), int'(ec == 0));
        chk({tag, " almost_full"}, int'(almost_full), int'(ec >= AFL));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(ec <= AEL));
        chk({tag, " overflow"}, int'(overflow), int'(eov));
        chk({tag, " underflow"}, int'(underflow), int'(eud));
    endtask

    task automatic step(input logic c, input logic w, input logic r, input logic [7:0] d);
        clear = c; wr_en = w; rd_en = r; din = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    bit m_ov, m_ud;

    initial begin
        // wrap, full-simultaneous, empty-simultaneous and clear scenarios
        vt = '{
            '{0,1,0,8'h11,1,8'h00,0,0}, '{0,1,0,8'h22,2,8'h00,0,0},
            '{0,1,0,8'h33,3,8'h00,0,0}, '{0,1,0,8'h44,4,8'h00,0,0},
            '{0,1,0,8'h55,4,8'h00,1,0},
            '{0,0,1,8'h00,3,8'h11,1,0}, '{0,0,1,8'h00,2,8'h22,1,0},
            '{0,0,1,8'h00,1,8'h33,1,0}, '{0,0,1,8'h00,0,8'h44,1,0},
            '{0,0,1,8'h00,0,8'h44,1,1},
            '{1,1,1,8'h66,0,8'h00,0,0},
            '{0,1,0,8'hA1,1,8'h00,0,0}, '{0,1,0,8'hA2,2,8'h00,0,0},
            '{0,1,0,8'hA3,3,8'h00,0,0},
            '{0,0,1,8'h00,2,8'hA1,0,0}, '{0,0,1,8'h00,1,8'hA2,0,0},
            '{0,1,0,8'hB1,2,8'hA2,0,0}, '{0,1,0,8'hB2,3,8'hA2,0,0},
            '{0,1,0,8'hB3,4,8'hA2,0,0},
            '{0,0,1,8'h00,3,8'hA3,0,0}, '{0,0,1,8'h00,2,8'hB1,0,0},
            '{0,0,1,8'h00,1,8'hB2,0,0}, '{0,0,1,8'h00,0,8'hB3,0,0},
            '{0,1,1,8'hC1,1,8'hB3,0,1},
            '{0,1,0,8'hC2,2,8'hB3,0,1}, '{0,1,0,8'hC3,3,8'hB3,0,1},
            '{0,1,0,8'hC4,4,8'hB3,0,1},
            '{0,1,1,8'hC5,4,8'hC1,0,1},
            '{0,0,1,8'h00,3,8'hC2,0,1}, '{0,0,1,8'h00,2,8'hC3,0,1},
            '{0,0,1,8'h00,1,8'hC4,0,1}, '{0,0,1,8'h00,0,8'hC5,0,1},
            '{1,0,0,8'h00,0,8'h00,0,0},
            '{0,1,0,8'hD1,1,8'h00,0,0}, '{0,1,0,8'hD2,2,8'h00,0,0},
            '{0,1,0,8'hD3,3,8'h00,0,0}, '{0,1,0,8'hD4,4,8'h00,0,0},
            '{0,1,0,8'hD5,4,8'h00,1,0},
            '{0,0,1,8'h00,3,8'hD1,1,0}, '{0,0,1,8'h00,2,8'hD2,1,0},
            '{1,0,0,8'h00,0,8'h00,0,0}
        };

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0);
        reset = 1'b1;
        step(0, 0, 0, 8'h00);
        chk_state("idle", 0, 0, 0, 0);

        foreach (vt[i]) begin
            step(vt[i].clr, vt[i].wr, vt[i].rd, vt[i].d);
            chk_state($sformatf("vec%0d", i), vt[i].ecount, int'(vt[i].edout), vt[i].eov, vt[i].eud);
        end

        // asynchronous reset in the middle of a write cycle
        step(0, 1, 0, 8'hE1);
        step(0, 1, 0, 8'hE2);
        step(0, 0, 1, 8'h00);
        chk_state("pre_async", 1, 8'hE1, 0, 0);
        wr_en = 1'b1; din = 8'hE3;
        #2;
        reset = 1'b0;
        #1;
        chk_state("async_reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_state("async_hold", 0, 0, 0, 0);
        wr_en = 1'b0;
        #2;
        reset = 1'b1;
        step(0, 0, 1, 8'h00);
        chk_state("post_async", 0, 0, 0, 1);
        step(1, 0, 0, 8'h00);

        m_dout = '0; m_ov = 0; m_ud = 0;
        for (int n = 0; n < 2000; n++) begin
            logic c, w, r;
            logic [7:0] d;
            bit racc;
            c = ($urandom_range(0, 63) == 0);
            w = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 1) == 1;
            d = 8'($urandom);
            step(c, w, r, d);
            if (c) begin
                mq.delete();
                m_dout = '0; m_ov = 0; m_ud = 0;
            end else begin
                racc = r && mq.size() > 0;
                if (racc) m_dout = mq.pop_front();
                else if (r) m_ud = 1;
                if (w && (mq.size() < DEPTH || racc)) mq.push_back(d);
                else if (w) m_ov = 1;
            end
            chk_state("rand", mq.size(), int'(m_dout), m_ov, m_ud);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Parametrised synchronous FIFO memory and the next generation of the team's 4-bit serial shift-register "FIFO". It stores DEPTH words of WIDTH bits with independent write and read strobes. It provides occupancy count, full/empty and programmable almost-full/almost-empty flags, plus sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain as a general-purpose buffer.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
AF_LEVEL, DEPTH-1, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush, active-high
wr_en  input  1  write request
din  input  WIDTH  write data
rd_en  input  1  read request
dout  output  WIDTH  registered read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - Write/read pointers and count go to 0; dout=0; overflow=underflow=0.
  - Flags follow from count=0: empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Storage array contents are not reset and are don't-care.
  - Reset asserted mid-transfer aborts the transfer immediately. No partial write or read is retained.
- Priority at each clock edge: reset > clear > wr/rd.
- clear=1: same result as reset, applied synchronously. Concurrent wr_en/rd_en are ignored and do not set the error flags.
- Write acceptance:
  - wr_acc = wr_en & (!full | rd_acc).
  - An accepted write stores din at wr_ptr, and wr_ptr increments modulo DEPTH.
- Read acceptance:
  - rd_acc = rd_en & !empty.
  - An accepted read loads mem[rd_ptr] into dout at the same edge, and rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle: data is visible on dout right after the edge where rd_en was sampled.
  - dout holds its value when no read is accepted.
- Simultaneous wr_en and rd_en:
  - Not full, not empty: both accepted; count unchanged.
  - Full: read accepted, write also accepted into the freed slot; count stays DEPTH; no overflow.
  - Empty: write accepted, read rejected. No write-through: dout unchanged, underflow set; count becomes 1.
- Rejected operations:
  - wr_en while full with no accepted read: data dropped, overflow<=1.
  - rd_en while empty: underflow<=1.
  - Both flags stay set until reset or clear.
- Count update: count <= count + wr_acc - rd_acc. Width is clog2(DEPTH+1), so DEPTH itself is representable.
- Flags:
  - full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
  - They reflect the state after the last edge.
- Pointer wrap: pointers are clog2(DEPTH) bits and wrap naturally. Ordering is strictly first-in first-out across the wrap.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, dout=0x00, almost_empty=1, overflow=underflow=0.
- Write 0x11,0x22,0x33,0x44 on 4 consecutive cycles → count 1,2,3,4; almost_full asserts at count=3; full=1 after 4th write. Then one more write of 0x55 → overflow=1, count stays 4.
- From full, read 4 times → dout 0x11,0x22,0x33,0x44, one cycle after each rd_en; empty=1 after the last read. A 5th read → underflow=1, dout holds 0x44.
- Wrap-around: write 3, read 2, write 3, read 4 → outputs in exact write order; pointers cross index 3→0 with no loss; count ends at 0.
- Simultaneous wr_en/rd_en:
  - When full: count stays 4, no overflow, new word emerges last.
  - When empty: count becomes 1, underflow=1, dout unchanged.
- With count=2 and overflow=1: pulse clear → next cycle count=0, empty=1, overflow=0. Separately, drop reset low mid-write → outputs return to reset values immediately, asynchronously to clk.
